// File: rtl/delay_ctrl.sv
// delay_ctrl: frame sequencer that programs the line delay and tags delayed pixel windows
// ports: clk, rst_n (async, active low); req_width/req_height/req_val/req_rdy frame request;
//        abort; cfg_delay/cfg_set delay-line programming; up_val pixel strobe;
//        win_val/win_col/win_row/win_last window tags; frame_done, err_cfg, err_drop pulses
module delay_ctrl #(
  parameter int HEIGHT_NB  = 3,
  parameter int MEM_AWIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  req_width,
  input  logic [CNT_WIDTH-1:0]  req_height,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic                  abort,
  output logic [MEM_AWIDTH-1:0] cfg_delay,
  output logic                  cfg_set,
  input  logic                  up_val,
  output logic                  win_val,
  output logic [CNT_WIDTH-1:0]  win_col,
  output logic [CNT_WIDTH-1:0]  win_row,
  output logic                  win_last,
  output logic                  frame_done,
  output logic                  err_cfg,
  output logic                  err_drop
);
  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] width, height, col, row, win_col_q, win_row_q;
  logic win_val_q, win_last_q, req_ok, accept, pix, drop, col_end, row_end, full_win;
  // 64-bit compare keeps the line-length limit meaningful for any MEM_AWIDTH/CNT_WIDTH mix
  assign req_ok = req_width >= CNT_WIDTH'(2) &&
                  (64'(req_width) - 64'd1) < (64'd1 << MEM_AWIDTH) &&
                  req_height >= CNT_WIDTH'(HEIGHT_NB);
  assign accept = state == IDLE && req_val && !abort;
  assign pix = state == RUN && up_val && !abort;
  assign drop = state != RUN && up_val && !abort;
  assign col_end = col == width - CNT_WIDTH'(1);
  assign row_end = row == height - CNT_WIDTH'(1);
  assign full_win = row >= CNT_WIDTH'(HEIGHT_NB - 1);
  always_comb begin
    state_nxt = abort ? IDLE :
                state == IDLE ? (accept && req_ok ? SET : IDLE) :
                state == SET ? RUN :
                state == RUN ? (pix && col_end && row_end ? DONE : RUN) : IDLE;
    req_rdy = state == IDLE;
    cfg_set = state == SET && !abort;
    frame_done = state == DONE && !abort;
    // abort blanks the tags in its own cycle; the registers are cleared at the following edge
    win_val = win_val_q && !abort;
    win_last = win_last_q && !abort;
    win_col = abort ? '0 : win_col_q;
    win_row = abort ? '0 : win_row_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      width <= '0;
      height <= '0;
      col <= '0;
      row <= '0;
      cfg_delay <= '0;
      win_val_q <= 1'b0;
      win_last_q <= 1'b0;
      win_col_q <= '0;
      win_row_q <= '0;
      err_cfg <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      err_cfg <= accept && !req_ok;
      err_drop <= drop;
      win_val_q <= pix && full_win;
      win_last_q <= pix && full_win && col_end && row_end;
      if (accept && req_ok) begin
        width <= req_width;
        height <= req_height;
        cfg_delay <= MEM_AWIDTH'(req_width - CNT_WIDTH'(1));
      end
      if (abort) begin
        col <= '0;
        row <= '0;
        win_col_q <= '0;
        win_row_q <= '0;
      end else if (state == SET) begin
        col <= '0;
        row <= '0;
      end else if (pix) begin
        win_col_q <= col;
        win_row_q <= row;
        col <= col_end ? '0 : col + CNT_WIDTH'(1);
        row <= col_end ? (row_end ? '0 : row + CNT_WIDTH'(1)) : row;
      end
    end
  end
endmodule
